// File: rtl/disp_pkg.sv
// Shared constants for the syscall/display controller: source selects, FSM
// encodings and the active-low hex-to-segment table.
package disp_pkg;

    localparam logic [1:0] SEL_PRINT = 2'd0;
    localparam logic [1:0] SEL_CYC   = 2'd1;
    localparam logic [1:0] SEL_SYS   = 2'd2;
    localparam logic [1:0] SEL_PC    = 2'd3;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Segments {g,f,e,d,c,b,a}, active-low; entry 15 is leftmost.
    localparam logic [15:0][6:0] HEX7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// Purely combinational nibble to active-low 7-segment decoder.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7_LUT[nibble];

endmodule

// File: rtl/syscall_disp_ctrl.sv
// Syscall decode (halt / print latch), display source mux and multiplexed
// 7-segment digit scanner for the pipelined MIPS core.
module syscall_disp_ctrl
    import disp_pkg::*;
#(
    parameter int          SCAN_DIV  = 100000,
    parameter int          NDIG      = 8,
    parameter logic [31:0] HALT_CODE = 32'h0000000A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall,
    input  logic [31:0] RF_A,
    input  logic [31:0] RF_B,
    input  logic [31:0] pc_in,
    input  logic [1:0]  sel,
    output logic        halt,
    output logic [31:0] disp_val,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [0:0]    state_q,     state_d;
    logic [31:0]   print_reg_q, print_reg_d;
    logic [31:0]   sys_cnt_q,   sys_cnt_d;
    logic [31:0]   cyc_cnt_q,   cyc_cnt_d;
    logic [31:0]   disp_val_q,  disp_val_d;
    logic [PW-1:0] presc_q,     presc_d;
    logic [2:0]    idx_q,       idx_d;
    logic [7:0]    an_q,        an_d;
    logic [7:0]    seg_q,       seg_d;
    logic [6:0]    seg7;
    logic          presc_wrap;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        print_reg_d = print_reg_q;
        sys_cnt_d   = sys_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        if (state_q == ST_RUN) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (syscall) begin
                if (RF_A == HALT_CODE) begin
                    state_d = ST_HALT;
                end else begin
                    print_reg_d = RF_B;
                    sys_cnt_d   = sys_cnt_q + 32'd1;
                end
            end
        end
    end

    always_comb begin
        disp_val_d = print_reg_q;
        unique case (sel)
            SEL_PRINT: disp_val_d = print_reg_q;
            SEL_CYC:   disp_val_d = cyc_cnt_q;
            SEL_SYS:   disp_val_d = sys_cnt_q;
            SEL_PC:    disp_val_d = pc_in;
        endcase
    end

    hex7seg u_hex7seg (
        .nibble (disp_val_q[{idx_q, 2'b00} +: 4]),
        .seg    (seg7)
    );

    // The digit index advances only when the prescaler wraps; an/seg follow idx a cycle later.
    always_comb begin
        presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == 3'(NDIG - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        an_d  = ~(8'd1 << idx_q);
        seg_d = {1'b1, seg7};
    end

    // NOTE: synchronous reset sampled on the clock edge; state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            print_reg_q <= '0;
            sys_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            disp_val_q  <= '0;
            presc_q     <= '0;
            idx_q       <= '0;
            an_q        <= 8'hFF;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            print_reg_q <= print_reg_d;
            sys_cnt_q   <= sys_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            disp_val_q  <= disp_val_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign halt     = (state_q == ST_HALT);
    assign disp_val = disp_val_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_syscall_disp_ctrl.sv
// Directed bench for syscall_disp_ctrl with a fast scan (SCAN_DIV=4, NDIG=8).
module tb_syscall_disp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall;
    logic [31:0] RF_A;
    logic [31:0] RF_B;
    logic [31:0] pc_in;
    logic [1:0]  sel;
    logic        halt;
    logic [31:0] disp_val;
    logic [7:0]  an;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edge   = 0;
    int freeze;
    logic [7:0] an_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    syscall_disp_ctrl #(
        .SCAN_DIV  (4),
        .NDIG      (8),
        .HALT_CODE (32'h0000000A)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .syscall  (syscall),
        .RF_A     (RF_A),
        .RF_B     (RF_B),
        .pc_in    (pc_in),
        .sel      (sel),
        .halt     (halt),
        .disp_val (disp_val),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_edge++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        n_edge = 0;
    endtask

    task automatic wait_an(input logic [7:0] target, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an == target) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        syscall = 1'b0;
        RF_A    = '0;
        RF_B    = '0;
        pc_in   = 32'hBFC0_0040;
        sel     = 2'd0;

        // Reset and the first scan window
        do_reset();
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_disp", disp_val, 32'd0);
        check("rst_an",   32'(an),   32'hFF);
        check("rst_seg",  32'(seg),  32'hFF);
        tick();
        check("first_halt", 32'(halt), 32'd0);
        check("first_disp", disp_val, 32'd0);
        check("first_an",   32'(an),   32'hFE);
        check("first_seg",  32'(seg),  32'hC0);

        // Digit scan: each enable held 4 cycles, FE..7F then wrap to FE
        for (int n = 2; n <= 36; n++) begin
            tick();
            check($sformatf("scan_an_%0d", n), 32'(an), 32'(an_exp[((n - 1) / 4) % 8]));
        end
        check("scan_seg", 32'(seg), 32'hC0);

        // Print syscall: value appears two edges later
        syscall = 1'b1; RF_A = 32'd1; RF_B = 32'h12345678; sel = 2'd0;
        tick();
        syscall = 1'b0; RF_B = '0;
        check("print_lat1", disp_val, 32'd0);
        tick();
        check("print_lat2", disp_val, 32'h12345678);
        wait_an(8'hFE, "wait_dig0");
        check("dig0_seg", 32'(seg), 32'h80);
        wait_an(8'hFB, "wait_dig2");
        check("dig2_seg", 32'(seg), 32'h82);
        wait_an(8'h7F, "wait_dig7");
        check("dig7_seg", 32'(seg), 32'hF9);
        sel = 2'd2;
        tick();
        check("sys_cnt_1", disp_val, 32'd1);
        sel = 2'd3;
        tick();
        check("pc_mode", disp_val, 32'hBFC0_0040);

        // Halt syscall, then an ignored syscall; counters frozen
        sel = 2'd1; syscall = 1'b1; RF_A = 32'h0000000A; RF_B = 32'h55;
        tick();
        freeze  = n_edge;
        syscall = 1'b0;
        check("halt_set", 32'(halt), 32'd1);
        syscall = 1'b1; RF_A = 32'd1; RF_B = 32'h0000DEAD;
        tick();
        syscall = 1'b0;
        check("cyc_frozen_0", disp_val, 32'(freeze));
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("cyc_frozen_%0d", i), disp_val, 32'(freeze));
        end
        check("halt_sticky", 32'(halt), 32'd1);
        sel = 2'd2;
        tick();
        check("sys_cnt_frozen", disp_val, 32'd1);
        sel = 2'd0;
        tick();
        check("print_frozen", disp_val, 32'h12345678);

        // cyc_cnt wrap from all-ones
        do_reset();
        sel = 2'd1;
        tick();
        dut.cyc_cnt_q = 32'hFFFF_FFFF;
        tick();
        check("wrap_cyc_q",  dut.cyc_cnt_q, 32'd0);
        check("wrap_disp_a", disp_val, 32'hFFFF_FFFF);
        tick();
        check("wrap_disp_b", disp_val, 32'd0);
        check("wrap_halt",   32'(halt), 32'd0);

        // Reset wins over a simultaneous halt syscall while halted
        syscall = 1'b1; RF_A = 32'h0000000A;
        tick();
        syscall = 1'b0;
        check("halt_again", 32'(halt), 32'd1);
        rst = 1'b1; syscall = 1'b1; RF_A = 32'h0000000A;
        tick();
        rst = 1'b0; syscall = 1'b0;
        check("rstw_halt",  32'(halt), 32'd0);
        check("rstw_state", 32'(dut.state_q), 32'd0);
        check("rstw_cyc",   dut.cyc_cnt_q, 32'd0);
        check("rstw_sys",   dut.sys_cnt_q, 32'd0);
        check("rstw_print", dut.print_reg_q, 32'd0);
        check("rstw_disp",  disp_val, 32'd0);
        check("rstw_an",    32'(an), 32'hFF);
        tick();
        check("rstw_an_scan", 32'(an), 32'hFE);
        check("rstw_halt_1",  32'(halt), 32'd0);
        check("rstw_cyc_1",   dut.cyc_cnt_q, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
